// File: rtl/uart_tx_fifo_engine_pkg.sv
// Shared definitions for the UART transmit engine: state encoding, counter widths
// and the parity helper used when a byte is captured from the TX FIFO.
package uart_tx_fifo_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int TICK_CNT_W         = 4;
    localparam int BIT_CNT_W          = 3;

    // Bit 7 only takes part in the parity when it is actually transmitted.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic       bit8,
                                         input logic       odd_n_even);
        return (^(data & {bit8, 7'h7F})) ^ odd_n_even;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Oversampling tick counter: flags the baud_tick that completes one serial bit
// and wraps so the next bit starts counting from zero.
module uart_tx_bit_timer
    import uart_tx_fifo_engine_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clock,
    input  logic aresetn,
    input  logic clear,
    input  logic baud_tick,
    output logic bit_done
);

    localparam logic [TICK_CNT_W-1:0] LAST_TICK = TICK_CNT_W'(OVERSAMPLE - 1);

    logic [TICK_CNT_W-1:0] tick_cnt;

    assign bit_done = baud_tick && !clear && (tick_cnt == LAST_TICK);

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (baud_tick) begin
            tick_cnt <= bit_done ? '0 : tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// UART transmit engine: fetches bytes from the TX FIFO with a single read strobe
// and serialises them as start / 7-or-8 data / optional parity / stop bits.
module uart_tx_fifo_engine
    import uart_tx_fifo_engine_pkg::*;
#(
    parameter int FIFO_RD_LATENCY = 2,
    parameter int OVERSAMPLE      = OVERSAMPLE_DEFAULT,
    parameter int STOP_BITS       = 1
) (
    input  logic       clock,
    input  logic       aresetn,
    input  logic       baud_tick,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_n,
    output logic       tx,
    output logic       tx_busy
);

    localparam int                     WAIT_W    = $clog2(FIFO_RD_LATENCY + 1);
    localparam logic [WAIT_W-1:0]      RD_LAT    = WAIT_W'(FIFO_RD_LATENCY);
    localparam logic [BIT_CNT_W-1:0]   LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   bit8_q, bit8_d;
    logic                   par_en_q, par_en_d;
    logic                   parity_q, parity_d;
    logic                   read_n_q, read_n_d;
    logic                   tx_q, tx_d;
    logic                   busy_q;
    logic                   timer_clear;
    logic                   bit_done;

    // The tick counter is held at zero until the first serial bit begins.
    assign timer_clear = (state_q == IDLE) || (state_q == WAIT);

    uart_tx_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clock     (clock),
        .aresetn   (aresetn),
        .clear     (timer_clear),
        .baud_tick (baud_tick),
        .bit_done  (bit_done)
    );

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        bit8_d   = bit8_q;
        par_en_d = par_en_q;
        parity_d = parity_q;
        read_n_d = 1'b1;
        tx_d     = 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    read_n_d = 1'b0;
                    wait_d   = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == RD_LAT) begin
                    shift_d  = fifo_data;
                    bit8_d   = bit8;
                    par_en_d = parity_en;
                    parity_d = calc_parity(fifo_data, bit8, odd_n_even);
                    bit_d    = '0;
                    state_d  = START;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_q == (bit8_q ? 3'd7 : 3'd6)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (bit_q == LAST_STOP) begin
                        // Back-to-back frames fetch the next byte straight from the stop bit.
                        if (!fifo_empty) begin
                            read_n_d = 1'b0;
                            wait_d   = '0;
                            state_d  = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            bit_q    <= '0;
            read_n_q <= 1'b1;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            bit_q    <= bit_d;
            read_n_q <= read_n_d;
            tx_q     <= tx_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Captured byte and frame configuration carry no reset; they are reloaded per frame.
    always_ff @(posedge clock) begin
        shift_q  <= shift_d;
        bit8_q   <= bit8_d;
        par_en_q <= par_en_d;
        parity_q <= parity_d;
    end

    assign fifo_read_n = read_n_q;
    assign tx          = tx_q;
    assign tx_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Scoreboard bench for uart_tx_fifo_engine: a FIFO model feeds bytes, expected
// serial frames are queued at push time and a line monitor decodes tx against them.
module tb_uart_tx_fifo_engine;

    typedef struct {
        int          n;
        logic [11:0] bits;
    } frame_t;

    logic       clock      = 1'b0;
    logic       aresetn    = 1'b1;
    logic       baud_tick  = 1'b0;
    logic       bit8       = 1'b1;
    logic       parity_en  = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h96;
    logic       fifo_read_n;
    logic       tx;
    logic       tx_busy;

    uart_tx_fifo_engine dut (
        .clock       (clock),
        .aresetn     (aresetn),
        .baud_tick   (baud_tick),
        .bit8        (bit8),
        .parity_en   (parity_en),
        .odd_n_even  (odd_n_even),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_n (fifo_read_n),
        .tx          (tx),
        .tx_busy     (tx_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tick_div = 1;
    int tick_cnt = 0;
    always @(posedge clock) begin
        if (tick_cnt >= tick_div - 1) begin
            tick_cnt  <= 0;
            baud_tick <= 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + 1;
            baud_tick <= 1'b0;
        end
    end

    // Sync FIFO model: data valid two clocks after the strobe cycle, junk otherwise.
    logic [7:0] fifo_q[$];
    logic       rd_pipe = 1'b0;
    logic [7:0] popped  = 8'h00;
    always @(posedge clock) begin
        rd_pipe <= 1'b0;
        if (aresetn && !fifo_read_n && fifo_q.size() > 0) begin
            popped  <= fifo_q.pop_front();
            rd_pipe <= 1'b1;
        end
        fifo_data  <= rd_pipe ? popped : 8'h96;
        fifo_empty <= (fifo_q.size() == 0);
    end

    int strobes     = 0;
    int bad_strobes = 0;
    always @(negedge clock) begin
        if (!fifo_read_n) begin
            strobes++;
            if (fifo_empty) bad_strobes++;
        end
    end

    frame_t exp_q[$];
    int     start_q[$];
    int     n_cmp  = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input int n, input logic [11:0] bits);
        frame_t f;
        f.n    = n;
        f.bits = bits;
        fifo_q.push_back(b);
        exp_q.push_back(f);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || tx_busy || fifo_q.size() != 0) && k < budget) begin
            @(negedge clock);
            k++;
        end
        check(name, (k < budget), 1);
    endtask

    task automatic wait_tx_low(input string name, input int budget);
        int k = 0;
        while (tx !== 1'b0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check(name, (k < budget), 1);
    endtask

    // Line monitor: samples each bit near its centre and compares whole frames.
    initial begin : monitor
        frame_t      e;
        logic [11:0] rx;
        bit          aborted;
        bit          expected;
        int          nframe;
        nframe = 0;
        forever begin
            @(negedge clock);
            if (aresetn && tx === 1'b0) begin
                start_q.push_back(cyc);
                expected = (exp_q.size() > 0);
                if (expected) begin
                    e = exp_q[0];
                end else begin
                    e.n    = 10;
                    e.bits = '0;
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, nothing queued", cyc);
                end
                rx      = '0;
                aborted = 1'b0;
                for (int i = 0; i < e.n && !aborted; i++) begin
                    for (int k = 0; k < ((i == 0) ? 8 : 16) * tick_div && !aborted; k++) begin
                        @(negedge clock);
                        if (!aresetn) aborted = 1'b1;
                    end
                    rx[i] = tx;
                end
                if (expected) begin
                    void'(exp_q.pop_front());
                    if (!aborted) check($sformatf("frame_%0d", nframe), rx, e.bits);
                end
                nframe++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s0;
        int st;
        int cnt;
        int lows;

        #2 aresetn = 1'b0;
        repeat (2) @(negedge clock);
        // 0x55 8N1 queued while reset is held
        push_byte(8'h55, 10, 12'h2AA);
        repeat (5) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_read_n", fifo_read_n, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_no_strobe", strobes, 0);
        aresetn = 1'b1;
        #1 check("release_read_n_before_edge", fifo_read_n, 1);
        @(negedge clock);
        check("first_strobe", fifo_read_n, 0);
        @(negedge clock);
        check("strobe_width", fifo_read_n, 1);
        wait_idle("idle_55", 2000);
        check("strobes_55", strobes, 1);
        check("tx_idle_55", tx, 1);

        // 0xA3 8E1 then 8O1; the second frame has its config scrambled mid-frame
        parity_en = 1'b1;
        odd_n_even = 1'b0;
        push_byte(8'hA3, 11, 12'h546);
        wait_idle("idle_a3_even", 2000);
        odd_n_even = 1'b1;
        push_byte(8'hA3, 11, 12'h746);
        wait_tx_low("start_a3_odd", 200);
        bit8 = 1'b0;
        parity_en = 1'b0;
        odd_n_even = 1'b0;
        wait_idle("idle_a3_odd", 2000);

        // 0xFF 7E1: start-bit edge to tx_busy fall is 10 bits of 16 clocks
        bit8 = 1'b0;
        parity_en = 1'b1;
        odd_n_even = 1'b0;
        push_byte(8'hFF, 10, 12'h3FE);
        wait_tx_low("start_ff", 200);
        cnt = 0;
        while (tx_busy && cnt < 400) begin
            @(negedge clock);
            cnt++;
        end
        check("frame_len_7e1", cnt, 160);
        wait_idle("idle_ff", 2000);

        // Three queued bytes, 8N1: frames start 160 + 3 clocks apart
        bit8 = 1'b1;
        parity_en = 1'b0;
        s0 = strobes;
        st = start_q.size();
        push_byte(8'h12, 10, 12'h224);
        push_byte(8'h34, 10, 12'h268);
        push_byte(8'hC7, 10, 12'h38E);
        wait_idle("idle_burst", 3000);
        repeat (200) @(negedge clock);
        check("burst_strobes", strobes - s0, 3);
        if (start_q.size() >= st + 3) begin
            check("burst_gap_1_2", start_q[st + 1] - start_q[st], 163);
            check("burst_gap_2_3", start_q[st + 2] - start_q[st + 1], 163);
        end else begin
            check("burst_frames_seen", start_q.size() - st, 3);
        end

        // Reset in the middle of data bit 3 with a tick every 4th clock
        tick_div = 4;
        s0 = strobes;
        push_byte(8'hF0, 10, 12'h3E0);
        cnt = 0;
        while (strobes == s0 && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        check("strobe_f0", (cnt < 100), 1);
        repeat (291) @(negedge clock);
        check("pre_reset_tx_bit3", tx, 0);
        #3 aresetn = 1'b0;
        #1;
        check("midframe_rst_tx", tx, 1);
        check("midframe_rst_busy", tx_busy, 0);
        check("midframe_rst_read_n", fifo_read_n, 1);
        repeat (3) @(negedge clock);
        aresetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("idle_after_reset", lows, 0);
        check("no_strobe_after_reset", strobes - s0, 1);
        // Fresh 7N1 frame: bit 7 of 0xB5 must not appear on the line
        bit8 = 1'b0;
        push_byte(8'hB5, 9, 12'h16A);
        wait_idle("idle_b5", 5000);
        check("strobes_after_reset", strobes - s0, 2);

        check("no_strobe_while_empty", bad_strobes, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
